// File: rtl/keyboard_ctrl.sv
// ---------------------------------------------------------------------------
// keyboard_ctrl
//   Control stage between the PS/2 byte receiver and a 4-digit 7-segment
//   display. It decodes the scan-code byte stream:
//     make codes
//     F0 break prefix
//     E0 extended prefix
//   Each newly pressed key is recorded in a 4-entry history buffer. The
//   buffer is time-multiplexed onto a shared segment decoder.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous reset, active-high
//   sc_valid  in   1  one-cycle strobe, sc holds a received byte
//   sc        in   8  received scan-code byte
//   num       out  8  scan code of the currently enabled digit
//   seg_en    out  4  digit enables, active-low, one-hot-low
//   new_key   out  1  one-cycle pulse the cycle after a push
// ---------------------------------------------------------------------------
module keyboard_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int TIMEOUT     = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sc_valid,
    input  logic [7:0] sc,
    output logic [7:0] num,
    output logic [3:0] seg_en,
    output logic       new_key
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT - 1);

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BREAK   = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t            r_state;
    logic [7:0]        r_held;
    logic [7:0]        r_buf [4];
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_new_key;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_idx;
    logic [7:0]        r_num;
    logic [3:0]        r_seg_en;

    logic              w_push;
    logic              w_div_wrap;
    logic              w_to_hit;

    // Push decision: a fresh make code in IDLE that differs from the held key.
    always_comb begin
        w_push     = 1'b0;
        w_div_wrap = (r_div == DIV_MAX);
        w_to_hit   = (r_to_cnt == TO_MAX);
        if (sc_valid && (r_state == ST_IDLE) && (sc != CODE_BRK) &&
            (sc != CODE_EXT) && (sc != r_held)) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // Scan-code decoder FSM with prefix timeout and new_key pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_held    <= 8'h00;
            r_to_cnt  <= '0;
            r_new_key <= 1'b0;
        end else begin
            r_new_key <= w_push;
            if (sc_valid) begin
                // Every consumed byte leaves or changes state, so the timer restarts.
                r_to_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (sc == CODE_BRK) begin
                            r_state <= ST_BREAK;
                        end else if (sc == CODE_EXT) begin
                            r_state <= ST_EXT;
                        end else begin
                            r_state <= ST_IDLE;
                            r_held  <= sc;
                        end
                    end
                    ST_BREAK: begin
                        r_state <= ST_IDLE;
                        if (sc == r_held) begin
                            r_held <= 8'h00;
                        end
                    end
                    ST_EXT: begin
                        r_state <= (sc == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (r_state != ST_IDLE) begin
                // A prefix with no follow-up byte is abandoned.
                if (w_to_hit) begin
                    r_state  <= ST_IDLE;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // History buffer: newest code at entry 0, oldest falls off entry 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_buf[3] <= r_buf[2];
            r_buf[2] <= r_buf[1];
            r_buf[1] <= r_buf[0];
            r_buf[0] <= sc;
        end
    end

    // Digit scan: refresh divider, digit index and registered display outputs.
    // num reloads from the buffer every cycle, so a push shows up without
    // waiting for the next digit advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= '0;
            r_idx    <= 2'd0;
            r_seg_en <= 4'b1110;
            r_num    <= 8'h00;
        end else begin
            r_div    <= w_div_wrap ? '0 : (r_div + DIV_W'(1));
            r_idx    <= w_div_wrap ? (r_idx + 2'd1) : r_idx;
            r_seg_en <= ~(4'b0001 << r_idx);
            r_num    <= r_buf[r_idx];
        end
    end

    assign num     = r_num;
    assign seg_en  = r_seg_en;
    assign new_key = r_new_key;

endmodule

// File: tb/tb_keyboard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keyboard_ctrl
//   Self-checking bench for keyboard_ctrl with REFRESH_DIV=4 and TIMEOUT=50.
//   A behavioural model tracks the key history list, the held key and the
//   prefix mode. It also tracks the elapsed-cycle count since reset, from
//   which the displayed digit follows. The model predicts num, seg_en and
//   new_key every cycle. Directed scenarios add end-state digit checks.
// ---------------------------------------------------------------------------
module tb_keyboard_ctrl;

    localparam int RD = 4;
    localparam int TO = 50;

    logic       clk;
    logic       rst;
    logic       sc_valid;
    logic [7:0] sc;
    logic [7:0] num;
    logic [3:0] seg_en;
    logic       new_key;

    keyboard_ctrl #(.REFRESH_DIV(RD), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .sc_valid (sc_valid),
        .sc       (sc),
        .num      (num),
        .seg_en   (seg_en),
        .new_key  (new_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int nk_cnt = 0;

    // Model state.
    // m_mode: 0 no prefix, 1 after F0, 2 after E0, 3 after E0 F0.
    logic [7:0] m_hist [4];
    logic [7:0] m_held;
    int         m_mode;
    int         m_quiet;
    int         m_cycles;
    logic [7:0] e_num;
    logic [3:0] e_seg;
    logic       e_nk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [7:0] b);
        int d;
        if (r) begin
            for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
            m_held = 8'h00; m_mode = 0; m_quiet = 0; m_cycles = 0;
            e_num = 8'h00; e_seg = 4'b1110; e_nk = 1'b0;
        end else begin
            // Displayed digit is the one selected by elapsed time before this edge.
            d = (m_cycles / RD) % 4;
            e_seg = ~(4'b0001 << d);
            e_num = m_hist[d];
            m_cycles++;
            e_nk = 1'b0;
            if (v) begin
                m_quiet = 0;
                if (m_mode == 0) begin
                    if (b == 8'hF0) m_mode = 1;
                    else if (b == 8'hE0) m_mode = 2;
                    else if (b != m_held) begin
                        m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1];
                        m_hist[1] = m_hist[0]; m_hist[0] = b;
                        m_held = b; e_nk = 1'b1;
                    end
                end else if (m_mode == 1) begin
                    if (b == m_held) m_held = 8'h00;
                    m_mode = 0;
                end else if (m_mode == 2) begin
                    m_mode = (b == 8'hF0) ? 3 : 0;
                end else begin
                    m_mode = 0;
                end
            end else if (m_mode != 0) begin
                // A prefix is abandoned on its TO-th quiet cycle.
                m_quiet++;
                if (m_quiet >= TO) begin
                    m_mode = 0;
                    m_quiet = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] b, input logic r);
        sc_valid = v; sc = b; rst = r;
        @(posedge clk);
        model_edge(r, v, b);
        #1;
        check_val("num", num, e_num);
        check_val("seg_en", seg_en, e_seg);
        check_val("new_key", new_key, e_nk);
        if (new_key === 1'b1) nk_cnt++;
    endtask

    task automatic do_reset();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        check_val("rst_seg", seg_en, 4'b1110);
        check_val("rst_num", num, 8'h00);
        check_val("rst_nk", new_key, 1'b0);
        nk_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    // Walk through every digit and compare against fixed expected codes.
    task automatic show_digits(input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        for (int i = 0; i < 4 * RD + 1; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            case (seg_en)
                4'b1110: check_val("dig0", num, e0);
                4'b1101: check_val("dig1", num, e1);
                4'b1011: check_val("dig2", num, e2);
                4'b0111: check_val("dig3", num, e3);
                default: check_val("seg_onehot", seg_en, 4'b1110);
            endcase
        end
    endtask

    logic [7:0] pool [8];

    initial begin
        sc_valid = 1'b0; sc = 8'h00; rst = 1'b1;
        pool[0] = 8'hF0; pool[1] = 8'hE0; pool[2] = 8'h1C; pool[3] = 8'h1C;
        pool[4] = 8'h16; pool[5] = 8'h00; pool[6] = 8'h75; pool[7] = 8'hF0;

        // 1: reset and idle scan
        do_reset();
        show_digits(8'h00, 8'h00, 8'h00, 8'h00);

        // 2: press/release, then the same key pressed again
        do_reset();
        send(8'h1C); send(8'hF0); send(8'h1C);
        check_val("s2_pulses", nk_cnt, 1);
        show_digits(8'h1C, 8'h00, 8'h00, 8'h00);
        send(8'h1C);
        check_val("s2_held_cleared", nk_cnt, 2);

        // 3: typematic repeat
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        check_val("s3_pulses", nk_cnt, 2);
        show_digits(8'h1C, 8'h1C, 8'h00, 8'h00);

        // 4: five keys, oldest dropped
        do_reset();
        send(8'h16); send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E);
        send(8'h26); send(8'hF0); send(8'h26);
        send(8'h25); send(8'hF0); send(8'h25);
        send(8'h2E); send(8'hF0); send(8'h2E);
        check_val("s4_pulses", nk_cnt, 5);
        show_digits(8'h2E, 8'h25, 8'h26, 8'h1E);

        // 5: extended keys ignored
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check_val("s5_no_push", nk_cnt, 0);
        send(8'h1C);
        check_val("s5_after", nk_cnt, 1);
        show_digits(8'h1C, 8'h00, 8'h00, 8'h00);

        // 6: prefix timeout, then reset aborting a prefix
        do_reset();
        tick(1'b1, 8'hF0, 1'b0);
        idle(60);
        send(8'h1C);
        check_val("s6_timeout", nk_cnt, 1);
        send(8'h22);
        tick(1'b1, 8'hF0, 1'b0);
        do_reset();
        send(8'h1C);
        check_val("s6_rst_abort", nk_cnt, 1);
        show_digits(8'h1C, 8'h00, 8'h00, 8'h00);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                tick(1'b0, 8'h00, 1'b1);
            end else if ($urandom_range(0, 99) == 0) begin
                idle(TO + $urandom_range(0, 8) - 4);
            end else if ($urandom_range(0, 3) == 0) begin
                tick(1'b1, pool[$urandom_range(0, 7)], 1'b0);
            end else begin
                tick(1'b0, 8'h00, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
